// File: rtl/blinkers_pkg.sv
// Shared types and LFSR helpers for the blinkers interval sources.
package blinkers_pkg;

   localparam int                LFSR_W       = 16;
   // Taps at bits 15, 13, 12 and 10 (x^16 + x^14 + x^13 + x^11 + 1, maximal length).
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] l);
      return ^(l & LFSR_TAPS);
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], lfsr_fb(l)};
   endfunction

   // An all-zero seed would lock the LFSR, so it is swapped for the default.
   function automatic logic [LFSR_W-1:0] legal_seed(input logic [LFSR_W-1:0] s);
      return (s == '0) ? DEFAULT_SEED : s;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR register with synchronous load (priority) and step enable.
module lfsr16
   import blinkers_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rstbtn_n,
   input  logic              step,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_data,
   output logic [LFSR_W-1:0] q
);

   // NOTE: registers update with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= load_data;
      end else if (step) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/blink_interval_lfsr.sv
// LED3 blink-interval source: rejection-samples LFSR bits into [MIN_INT, MAX_INT]
// and offers each value on a valid/ready handshake, falling back to MIN_INT.
module blink_interval_lfsr
   import blinkers_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                IW        = 4,
   parameter int                MIN_INT   = 2,
   parameter int                MAX_INT   = 15,
   parameter int                MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              rstbtn_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_data,
   output logic [IW-1:0]     interval,
   output logic              interval_valid,
   input  logic              interval_ready,
   output logic [7:0]        reject_cnt,
   output logic [LFSR_W-1:0] lfsr_state
);

   localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);
   // One extra bit keeps the range test meaningful when MAX_INT is the all-ones value.
   localparam logic [IW:0]       MIN_EXT  = (IW+1)'(MIN_INT);
   localparam logic [IW:0]       MAX_EXT  = (IW+1)'(MAX_INT);
   localparam logic [IW-1:0]     FALLBACK = IW'(MIN_INT);
   localparam logic [LFSR_W-1:0] SEED_OK  = legal_seed(SEED);

   state_e           state_q, state_d;
   logic [IW-1:0]    interval_q, interval_d;
   logic [TRY_W-1:0] try_q, try_d;
   logic [7:0]       rej_q, rej_d;
   logic             step;
   logic [IW:0]      cand;
   logic             in_range;

   lfsr16 #(
      .RESET_VAL(SEED_OK)
   ) u_lfsr (
      .clk      (clk),
      .rstbtn_n (rstbtn_n),
      .step     (step),
      .load     (seed_load),
      .load_data(legal_seed(seed_data)),
      .q        (lfsr_state)
   );

   // Low IW bits of the post-step LFSR value, without forming the whole next word.
   assign cand     = {1'b0, lfsr_state[IW-2:0], lfsr_fb(lfsr_state)};
   assign in_range = (cand >= MIN_EXT) && (cand <= MAX_EXT);
   assign step     = (state_q == FILL) && !seed_load;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      interval_d = interval_q;
      try_d      = try_q;
      rej_d      = rej_q;
      if (seed_load) begin
         state_d = FILL;
         try_d   = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (in_range) begin
                  interval_d = cand[IW-1:0];
                  try_d      = '0;
                  state_d    = HOLD;
               end else begin
                  if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
                  if (try_q == TRY_LAST) begin
                     interval_d = FALLBACK;
                     try_d      = '0;
                     state_d    = HOLD;
                  end else begin
                     try_d = try_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (interval_ready) state_d = FILL;
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         state_q    <= FILL;
         interval_q <= '0;
         try_q      <= '0;
         rej_q      <= '0;
      end else begin
         state_q    <= state_d;
         interval_q <= interval_d;
         try_q      <= try_d;
         rej_q      <= rej_d;
      end
   end

   // HOLD is exactly the offering state, so valid is the decoded state bit.
   assign interval_valid = (state_q == HOLD);
   assign interval       = interval_q;
   assign reject_cnt     = rej_q;

endmodule

// File: tb/tb_blink_interval_lfsr.sv
// Self-checking bench for blink_interval_lfsr: directed vectors plus a reference model.
module tb_blink_interval_lfsr;

   localparam int MIN_I = 2;
   localparam int MAX_I = 15;
   localparam int MAX_T = 8;

   logic        clk = 1'b0;
   logic        rstbtn_n = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed_data = 16'h0000;
   logic        interval_ready = 1'b0;
   logic [3:0]  interval;
   logic        interval_valid;
   logic [7:0]  reject_cnt;
   logic [15:0] lfsr_state;

   logic        seed_load_mt = 1'b0;
   logic [15:0] seed_data_mt = 16'h0000;
   logic        interval_ready_mt = 1'b0;
   logic [3:0]  interval_mt;
   logic        interval_valid_mt;
   logic [7:0]  reject_cnt_mt;
   logic [15:0] lfsr_state_mt;

   int n_checks = 0;
   int n_errors = 0;
   bit range_mon = 1'b0;

   always #5 clk = ~clk;

   blink_interval_lfsr dut (
      .clk           (clk),
      .rstbtn_n      (rstbtn_n),
      .seed_load     (seed_load),
      .seed_data     (seed_data),
      .interval      (interval),
      .interval_valid(interval_valid),
      .interval_ready(interval_ready),
      .reject_cnt    (reject_cnt),
      .lfsr_state    (lfsr_state)
   );

   blink_interval_lfsr #(.MAX_TRIES(1)) dut_mt1 (
      .clk           (clk),
      .rstbtn_n      (rstbtn_n),
      .seed_load     (seed_load_mt),
      .seed_data     (seed_data_mt),
      .interval      (interval_mt),
      .interval_valid(interval_valid_mt),
      .interval_ready(interval_ready_mt),
      .reject_cnt    (reject_cnt_mt),
      .lfsr_state    (lfsr_state_mt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference model: one transaction-level update per clock from the rules of the block.
   logic [15:0] m_lfsr  = 16'hACE1;
   logic [3:0]  m_int   = 4'd0;
   bit          m_valid = 1'b0;
   int          m_tries = 0;
   int          m_rej   = 0;

   function automatic logic [15:0] m_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic int m_cand(input logic [15:0] l);
      return int'(m_next(l)) % 16;
   endfunction

   always @(posedge clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         m_lfsr  <= 16'hACE1;
         m_int   <= 4'd0;
         m_valid <= 1'b0;
         m_tries <= 0;
         m_rej   <= 0;
      end else if (seed_load) begin
         m_lfsr  <= (seed_data == 16'h0000) ? 16'hACE1 : seed_data;
         m_tries <= 0;
         m_valid <= 1'b0;
      end else if (m_valid) begin
         if (interval_ready) m_valid <= 1'b0;
      end else begin
         m_lfsr <= m_next(m_lfsr);
         if (m_cand(m_lfsr) >= MIN_I && m_cand(m_lfsr) <= MAX_I) begin
            m_int   <= 4'(m_cand(m_lfsr));
            m_valid <= 1'b1;
            m_tries <= 0;
         end else begin
            m_rej <= (m_rej < 255) ? m_rej + 1 : 255;
            if (m_tries + 1 >= MAX_T) begin
               m_int   <= 4'(MIN_I);
               m_valid <= 1'b1;
               m_tries <= 0;
            end else begin
               m_tries <= m_tries + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_valid",    32'(interval_valid), 32'(m_valid));
      check("cmp_interval", 32'(interval),       32'(m_int));
      check("cmp_lfsr",     32'(lfsr_state),     32'(m_lfsr));
      check("cmp_reject",   32'(reject_cnt),     32'(m_rej));
      if (range_mon && interval_valid)
         check("interval_range", 32'(interval >= 4'(MIN_I) && interval <= 4'(MAX_I)), 32'd1);
   end

   initial begin
      repeat (3) tick();
      check("rst_valid",    32'(interval_valid), 32'd0);
      check("rst_interval", 32'(interval),       32'd0);
      check("rst_lfsr",     32'(lfsr_state),     32'h0000ACE1);
      check("rst_reject",   32'(reject_cnt),     32'd0);

      // First offer one cycle after release, then held while ready stays low.
      rstbtn_n = 1'b1;
      tick();
      check("first_valid",    32'(interval_valid), 32'd1);
      check("first_interval", 32'(interval),       32'd3);
      check("first_lfsr",     32'(lfsr_state),     32'h000059C3);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_interval", 32'(interval),   32'd3);
         check("hold_lfsr",     32'(lfsr_state), 32'h000059C3);
      end

      interval_ready = 1'b1;
      tick();
      interval_ready = 1'b0;
      check("xfer_gap_valid", 32'(interval_valid), 32'd0);
      tick();
      check("second_valid",    32'(interval_valid), 32'd1);
      check("second_interval", 32'(interval),       32'd7);
      check("second_lfsr",     32'(lfsr_state),     32'h0000B387);

      // Reseed to 0x8000: candidate 1 is rejected once, then 2 is accepted.
      seed_load = 1'b1;
      seed_data = 16'h8000;
      tick();
      seed_load = 1'b0;
      check("seed_lfsr",  32'(lfsr_state),     32'h00008000);
      check("seed_valid", 32'(interval_valid), 32'd0);
      tick();
      check("rej_valid",  32'(interval_valid), 32'd0);
      check("rej_count",  32'(reject_cnt),     32'd1);
      check("rej_lfsr",   32'(lfsr_state),     32'h00000001);
      tick();
      check("acc_valid",    32'(interval_valid), 32'd1);
      check("acc_interval", 32'(interval),       32'd2);
      check("acc_lfsr",     32'(lfsr_state),     32'h00000002);

      // Single-try instance falls back to MIN_INT on the first rejection.
      seed_load_mt = 1'b1;
      seed_data_mt = 16'h8000;
      tick();
      seed_load_mt = 1'b0;
      check("mt1_seed_lfsr", 32'(lfsr_state_mt), 32'h00008000);
      tick();
      check("mt1_valid",    32'(interval_valid_mt), 32'd1);
      check("mt1_interval", 32'(interval_mt),       32'd2);
      check("mt1_reject",   32'(reject_cnt_mt),     32'd1);
      check("mt1_lfsr",     32'(lfsr_state_mt),     32'h00000001);

      // Zero seed with a coincident transfer: default seed, offer withdrawn.
      seed_load      = 1'b1;
      seed_data      = 16'h0000;
      interval_ready = 1'b1;
      tick();
      seed_load      = 1'b0;
      interval_ready = 1'b0;
      check("zseed_valid", 32'(interval_valid), 32'd0);
      check("zseed_lfsr",  32'(lfsr_state),     32'h0000ACE1);
      tick();
      check("zseed_next_valid",    32'(interval_valid), 32'd1);
      check("zseed_next_interval", 32'(interval),       32'd3);

      // Asynchronous reset between edges while an offer is pending.
      #2 rstbtn_n = 1'b0;
      #1;
      check("async_valid",    32'(interval_valid), 32'd0);
      check("async_interval", 32'(interval),       32'd0);
      check("async_lfsr",     32'(lfsr_state),     32'h0000ACE1);
      check("async_reject",   32'(reject_cnt),     32'd0);
      tick();
      rstbtn_n       = 1'b1;
      interval_ready = 1'b1;
      range_mon      = 1'b1;
      tick();
      check("rerun_first_interval", 32'(interval), 32'd3);
      repeat (1000) tick();

      begin
         int guard = 0;
         while (m_rej < 255 && guard < 20000) begin
            tick();
            guard++;
         end
      end
      check("reject_saturated", 32'(reject_cnt), 32'd255);
      repeat (50) tick();
      check("reject_sat_hold", 32'(reject_cnt), 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
